// File: rtl/udm_uart_rx.sv
// udm_uart_rx: 8-bit UART receiver with a runtime bit-period divider.
// The incoming line is synchronized, the start bit is qualified at mid-bit,
// and data/stop bits are sampled at their centres. A single holding
// register feeds a valid/ready consumer.
// Optional macro UDM_UART_RX_PARITY_EN adds an even-parity bit between the
// data bits and the stop bit (frame 8E1 instead of 8N1).
module udm_uart_rx #(
    parameter int DIV_W = 16
) (
    input  logic             clk_i,
    input  logic             srst_n_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic             rx_i,
    output logic [7:0]       rx_data_o,
    output logic             rx_valid_o,
    input  logic             rx_ready_i,
    output logic             busy_o,
    output logic             frame_err_o,
    output logic             overrun_o,
    output logic             parity_err_o
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef UDM_UART_RX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd3;
`endif
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic [2:0] ST_BREAK  = 3'd5;

    logic             rx_sync_p0;
    logic             rx_s;
    logic [2:0]       state;
    logic [DIV_W-1:0] div_l;
    logic [DIV_W-1:0] cnt;
    logic [7:0]       shift;
    logic [2:0]       bit_idx;
    // Good frame waiting to be handed to the holding register next cycle.
    logic             vld_p1;
    logic             expire;
`ifdef UDM_UART_RX_PARITY_EN
    logic             par_bad;
`endif

    assign expire = (cnt == DIV_W'(1));
    assign busy_o = (state != ST_IDLE);

    // Two-flop synchronizer for the asynchronous line; resets to idle-high.
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            rx_sync_p0 <= 1'b1;
            rx_s       <= 1'b1;
        end else begin
            rx_sync_p0 <= rx_i;
            rx_s       <= rx_sync_p0;
        end
    end

    // Frame state machine and error pulses.
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            state        <= ST_IDLE;
            vld_p1       <= 1'b0;
            frame_err_o  <= 1'b0;
`ifdef UDM_UART_RX_PARITY_EN
            parity_err_o <= 1'b0;
            par_bad      <= 1'b0;
`endif
        end else begin
            vld_p1      <= 1'b0;
            frame_err_o <= 1'b0;
`ifdef UDM_UART_RX_PARITY_EN
            parity_err_o <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (!rx_s) state <= ST_START;
                end
                ST_START: begin
                    // A line that is high again at mid-start was a glitch.
                    if (expire) begin
                        state <= rx_s ? ST_IDLE : ST_DATA;
`ifdef UDM_UART_RX_PARITY_EN
                        par_bad <= 1'b0;
`endif
                    end
                end
                ST_DATA: begin
                    if (expire && bit_idx == 3'd7) begin
`ifdef UDM_UART_RX_PARITY_EN
                        state <= ST_PARITY;
`else
                        state <= ST_STOP;
`endif
                    end
                end
`ifdef UDM_UART_RX_PARITY_EN
                ST_PARITY: begin
                    // Even parity: the parity bit makes the total count of ones even.
                    if (expire) begin
                        state <= ST_STOP;
                        if (rx_s != ^shift) begin
                            parity_err_o <= 1'b1;
                            par_bad      <= 1'b1;
                        end
                    end
                end
`endif
                ST_STOP: begin
                    if (expire) begin
                        if (rx_s) begin
                            state <= ST_IDLE;
`ifdef UDM_UART_RX_PARITY_EN
                            vld_p1 <= !par_bad;
`else
                            vld_p1 <= 1'b1;
`endif
                        end else begin
                            frame_err_o <= 1'b1;
                            state       <= ST_BREAK;
                        end
                    end
                end
                ST_BREAK: begin
                    // Hold off until the line idles so a long low is not seen as a start.
                    if (rx_s) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifndef UDM_UART_RX_PARITY_EN
    assign parity_err_o = 1'b0;
`endif

    // Bit-period counter and shift register; divider is frozen at frame start.
    always_ff @(posedge clk_i) begin
        case (state)
            ST_IDLE: begin
                if (!rx_s) begin
                    div_l <= div_i;
                    cnt   <= div_i >> 1;
                end
            end
            ST_START: begin
                if (expire) begin
                    cnt     <= div_l;
                    bit_idx <= 3'd0;
                end else begin
                    cnt <= cnt - DIV_W'(1);
                end
            end
            ST_DATA: begin
                if (expire) begin
                    cnt     <= div_l;
                    shift   <= {rx_s, shift[7:1]};
                    bit_idx <= bit_idx + 3'd1;
                end else begin
                    cnt <= cnt - DIV_W'(1);
                end
            end
`ifdef UDM_UART_RX_PARITY_EN
            ST_PARITY,
`endif
            ST_STOP: begin
                if (expire) cnt <= div_l;
                else        cnt <= cnt - DIV_W'(1);
            end
            default: ;
        endcase
    end

    // Holding register with valid/ready handshake and overrun detection.
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            rx_data_o  <= 8'h00;
            rx_valid_o <= 1'b0;
            overrun_o  <= 1'b0;
        end else begin
            overrun_o <= 1'b0;
            if (vld_p1) begin
                if (!rx_valid_o || rx_ready_i) begin
                    rx_data_o  <= shift;
                    rx_valid_o <= 1'b1;
                end else begin
                    overrun_o <= 1'b1;
                end
            end else if (rx_ready_i) begin
                rx_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_udm_uart_rx.sv
// Testbench for udm_uart_rx: serial frames are bit-banged on rx_i, expected
// bytes are queued when a frame is sent and popped on every valid/ready
// transfer. Error pulses and valid rises are tallied by a negedge monitor.
module tb_udm_uart_rx;

    localparam int DIV_W = 16;

    logic             clk;
    logic             srst_n;
    logic [DIV_W-1:0] div;
    logic             rx;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             rx_ready;
    logic             busy;
    logic             frame_err;
    logic             overrun;
    logic             parity_err;

    int   n_chk  = 0;
    int   n_fail = 0;
    logic [7:0] exp_q[$];
    int   fe_cnt = 0, ov_cnt = 0, pe_cnt = 0, rise_cnt = 0, hi_cnt = 0;
    time  t_start = 0, last_rise_t = 0;

    udm_uart_rx #(.DIV_W(DIV_W)) dut (
        .clk_i       (clk),
        .srst_n_i    (srst_n),
        .div_i       (div),
        .rx_i        (rx),
        .rx_data_o   (rx_data),
        .rx_valid_o  (rx_valid),
        .rx_ready_i  (rx_ready),
        .busy_o      (busy),
        .frame_err_o (frame_err),
        .overrun_o   (overrun),
        .parity_err_o(parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one frame; leaves rx at stop_val afterwards.
    task automatic send_frame(input logic [7:0] b, input int d, input bit flip_par,
                              input bit stop_val, input int stop_len);
        rx = 1'b0;
        t_start = $time + 9;
        wait_clks(d);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_clks(d);
        end
`ifdef UDM_UART_RX_PARITY_EN
        rx = (^b) ^ flip_par;
        wait_clks(d);
`else
        if (flip_par) $display("note: parity flip ignored in 8N1 build");
`endif
        rx = stop_val;
        wait_clks(d * stop_len);
    endtask

    // Monitor: scoreboard pops on transfers, pulse and rise tallies.
    initial begin
        logic prev_vld;
        logic [7:0] e;
        prev_vld = 1'b0;
        forever begin
            @(negedge clk);
            if (rx_valid && !prev_vld) begin
                rise_cnt++;
                last_rise_t = $time - 5;
            end
            prev_vld = rx_valid;
            if (rx_valid) hi_cnt++;
            if (rx_valid && rx_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    chk("rx_data", {24'h0, rx_data}, {24'h0, e});
                end
            end
            if (frame_err)  fe_cnt++;
            if (overrun)    ov_cnt++;
            if (parity_err) pe_cnt++;
        end
    end

    initial begin
        int r0, f0, o0, h0, lat, extra;
`ifdef UDM_UART_RX_PARITY_EN
        extra = 1;
`else
        extra = 0;
`endif
        srst_n   = 1'b0;
        div      = 16'd8;
        rx       = 1'b1;
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        wait_clks(3);
        chk("rst_valid", rx_valid, 0);
        chk("rst_data", rx_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_perr", parity_err, 0);
        srst_n = 1'b1;
        wait_clks(4);

        // Single byte, ready high: one-cycle valid at fixed latency.
        r0 = rise_cnt; h0 = hi_cnt;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 8, 1'b0, 1'b1, 1);
        wait_clks(4);
        lat = int'((last_rise_t - t_start) / 10);
        chk("a5_latency", lat, 79 + 8 * extra);
        chk("a5_rises", rise_cnt - r0, 1);
        chk("a5_hi_cycles", hi_cnt - h0, 1);

        // Start-bit glitch: two low clocks only.
        r0 = rise_cnt; f0 = fe_cnt;
        rx = 1'b0;
        wait_clks(2);
        rx = 1'b1;
        wait_clks(2);
        chk("glitch_busy_hi", busy, 1);
        wait_clks(3);
        chk("glitch_busy_lo", busy, 0);
        wait_clks(20);
        chk("glitch_no_valid", rise_cnt - r0, 0);
        chk("glitch_no_ferr", fe_cnt - f0, 0);

        // Stop bit held low for three bit times.
        r0 = rise_cnt; f0 = fe_cnt;
        send_frame(8'h3C, 8, 1'b0, 1'b0, 3);
        chk("brk_busy_hi", busy, 1);
        chk("brk_ferr", fe_cnt - f0, 1);
        rx = 1'b1;
        wait_clks(4);
        chk("brk_busy_lo", busy, 0);
        chk("brk_no_valid", rise_cnt - r0, 0);
        wait_clks(10);

        // Overrun: consumer stalled across two back-to-back frames.
        rx_ready = 1'b0;
        o0 = ov_cnt;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 8, 1'b0, 1'b1, 1);
        send_frame(8'h22, 8, 1'b0, 1'b1, 1);
        wait_clks(4);
        chk("ovr_pulse", ov_cnt - o0, 1);
        chk("ovr_keep_data", rx_data, 8'h11);
        chk("ovr_valid", rx_valid, 1);
        rx_ready = 1'b1;
        wait_clks(2);
        chk("ovr_drained", rx_valid, 0);
        rx_ready = 1'b0;
        wait_clks(10);

        // Same pair, but ready pulses exactly on the 0x22 load cycle.
        o0 = ov_cnt;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        send_frame(8'h11, 8, 1'b0, 1'b1, 1);
        fork
            send_frame(8'h22, 8, 1'b0, 1'b1, 1);
            begin
                wait_clks(78 + 8 * extra);
                rx_ready = 1'b1;
                wait_clks(1);
                rx_ready = 1'b0;
            end
        join
        wait_clks(4);
        chk("drain_no_ovr", ov_cnt - o0, 0);
        chk("drain_data", rx_data, 8'h22);
        chk("drain_valid", rx_valid, 1);
        rx_ready = 1'b1;
        wait_clks(3);

        // Reset in the middle of 0xFF at D=16, then 0x5A with div_i disturbed mid-frame.
        div = 16'd16;
        r0 = rise_cnt;
        fork
            send_frame(8'hFF, 16, 1'b0, 1'b1, 1);
            begin
                wait_clks(16 + 4 * 16 + 8);
                srst_n = 1'b0;
                wait_clks(2);
                chk("mid_rst_busy", busy, 0);
                srst_n = 1'b1;
            end
        join
        wait_clks(10);
        chk("mid_rst_no_valid", rise_cnt - r0, 0);
        exp_q.push_back(8'h5A);
        fork
            send_frame(8'h5A, 16, 1'b0, 1'b1, 1);
            begin
                wait_clks(40);
                div = 16'd5;
                wait_clks(40);
                div = 16'd16;
            end
        join
        wait_clks(4);
        lat = int'((last_rise_t - t_start) / 10);
        chk("d16_latency", lat, 155 + 16 * extra);
        chk("d16_rises", rise_cnt - r0, 1);
        div = 16'd8;
        wait_clks(5);

`ifdef UDM_UART_RX_PARITY_EN
        // Parity: correct bit delivers, wrong bit pulses and drops.
        r0 = rise_cnt;
        exp_q.push_back(8'h07);
        send_frame(8'h07, 8, 1'b0, 1'b1, 1);
        wait_clks(4);
        chk("par_ok_rise", rise_cnt - r0, 1);
        chk("par_ok_perr", pe_cnt, 0);
        r0 = rise_cnt;
        send_frame(8'h07, 8, 1'b1, 1'b1, 1);
        wait_clks(4);
        chk("par_bad_perr", pe_cnt, 1);
        chk("par_bad_no_rise", rise_cnt - r0, 0);
`else
        chk("no_parity_pulses", pe_cnt, 0);
`endif

        wait_clks(5);
        chk("sb_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/udm_uart_rx.md
UDM_UART_RX -- requirements
Module: udm_uart_rx

Interface
REQ-001 SHALL have parameter DIV_W, default 16, giving the width of the bit-period divider input.
REQ-002 SHALL have port clk_i  input  1  system clock; one clock domain, all logic on the rising edge.
REQ-003 SHALL have port srst_n_i  input  1  reset; synchronous and active-low.
REQ-004 SHALL have port div_i  input  DIV_W  clocks per UART bit (D); legal range 4..2^DIV_W-1.
REQ-005 SHALL have port rx_i  input  1  asynchronous UART serial line; idle high.
REQ-006 SHALL have port rx_data_o  output  8  received byte.
REQ-007 SHALL have port rx_valid_o  output  1  rx_data_o holds an unconsumed byte.
REQ-008 SHALL have port rx_ready_i  input  1  consumer accepts the byte; transfer when valid and ready are both high.
REQ-009 SHALL have port busy_o  output  1  high while the FSM is not in IDLE.
REQ-010 SHALL have port frame_err_o  output  1  one-cycle pulse on a bad stop bit.
REQ-011 SHALL have port overrun_o  output  1  one-cycle pulse when a completed byte is dropped.
REQ-012 SHALL have port parity_err_o  output  1  one-cycle pulse on a parity mismatch; tied 0 without the macro.

Function
REQ-013 SHALL pass rx_i through a 2-flop synchronizer; all decisions use the synchronized value (rx_s).
REQ-014 SHALL implement the FSM states IDLE, START, DATA, PARITY (macro only), STOP and BREAK.
REQ-015 IDLE: on rx_s==0, latch div_i into D_l, load the counter with D_l>>1, and go to START; a change to div_i mid-frame SHALL have no effect.
REQ-016 START: when the counter expires, sample rx_s; if 1 (glitch), go to IDLE with no outputs; if 0, reload the counter with D_l and go to DATA.
REQ-017 DATA: sample one bit each time the counter expires, filling LSB first; after 8 bits, go to PARITY (macro) or STOP.
REQ-018 STOP: sample at mid-bit; if 1, the frame is good; if 0, pulse frame_err_o, discard the byte, and go to BREAK.
REQ-019 BREAK: wait for rx_s==1, then go to IDLE.
REQ-020 Good frame, holding register empty or being drained (rx_ready_i high the same cycle): load rx_data_o and keep or assert rx_valid_o; no overrun.
REQ-021 Good frame, holding register full and rx_ready_i low: keep the old byte and pulse overrun_o.
REQ-022 rx_valid_o SHALL fall on the edge after a transfer unless a new byte loads in the same cycle.
REQ-023 rx_valid_o SHALL rise exactly 3 + (D>>1) + 9*D clocks after the first edge at which rx_i is sampled low, plus D with the macro.
REQ-024 After a good stop bit, the FSM SHALL return to IDLE in the next cycle, so back-to-back frames with one stop bit are received.
REQ-025 Counter width SHALL be DIV_W; the counter is decremented to 1 and the sample is taken on the expiry cycle; no wrap-around is permitted.

Reset
REQ-026 When srst_n_i==0 at a clock edge, the FSM SHALL enter IDLE.
REQ-027 Reset SHALL set the synchronizer flops to 1, rx_data_o=8'h00, and rx_valid_o, busy_o, frame_err_o, overrun_o and parity_err_o to 0.
REQ-028 Reset mid-frame SHALL discard the partial byte; reception resumes with the next falling edge after release.

Configuration
REQ-029 Macro UDM_UART_RX_PARITY_EN defined: the frame is 8 data bits + even parity + stop. PARITY samples the parity bit; on mismatch, pulse parity_err_o and discard the byte. The stop bit is still checked.
REQ-030 Macro UDM_UART_RX_PARITY_EN undefined: there is no PARITY state, the frame is 8N1, and parity_err_o is constant 0.

Verification
REQ-031 D=8, 8N1, send 0xA5, rx_ready_i=1 -> rx_valid_o high for 1 cycle, 79 clocks after the start edge, with rx_data_o=0xA5.
REQ-032 D=8, rx_i low for 2 clocks then high -> no rx_valid_o, no error pulse, busy_o back to 0 within 5 clocks.
REQ-033 D=8, send 0x3C with the stop bit driven 0 for 3 bit times -> frame_err_o pulse, no rx_valid_o, busy_o low only after rx_i returns high.
REQ-034 D=8, rx_ready_i=0, send 0x11 then 0x22 back-to-back -> overrun_o pulse, rx_data_o stays 0x11. Repeat with rx_ready_i=1 at the 0x22 completion cycle -> no overrun, rx_data_o=0x22.
REQ-035 D=16, assert srst_n_i=0 during data bit 4 of 0xFF, release, then send 0x5A -> only 0x5A is delivered.
REQ-036 With UDM_UART_RX_PARITY_EN: send 0x07 with parity 1 -> rx_valid_o with 0x07; send 0x07 with parity 0 -> parity_err_o pulse, no rx_valid_o.
